// File: rtl/shifter_pipe_if.sv
// Handshake bundle for shifter_pipe: operand/tag request side and result side.
// The slave modport is the shifter's view; the master modport is the requester's.
interface shifter_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             i_valid;
  logic             o_ready;
  logic [2:0]       i_sel;
  logic [WIDTH-1:0] i_shifter_a;
  logic [WIDTH-1:0] i_shifter_b;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_data;
  logic [TAG_W-1:0] o_tag;

  modport slave (
    input  i_valid, i_sel, i_shifter_a, i_shifter_b, i_tag, i_ready,
    output o_ready, o_valid, o_data, o_tag
  );

  modport master (
    output i_valid, i_sel, i_shifter_a, i_shifter_b, i_tag, i_ready,
    input  o_ready, o_valid, o_data, o_tag
  );
endinterface

// File: rtl/shifter_pipe.sv
// Fully pipelined barrel shifter: stage k conditionally shifts/rotates by 2^k,
// with per-stage valid/ready backpressure, a sideband tag, and a synchronous flush.
module shifter_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH),
  parameter int TAG_W = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_flush,
  shifter_pipe_if.slave  bus
);

  typedef enum logic [2:0] {
    MODE_SLL = 3'b000,
    MODE_SRL = 3'b001,
    MODE_SRA = 3'b010,
    MODE_ROL = 3'b011,
    MODE_ROR = 3'b100
  } mode_e;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [2:0]       mode;
    logic [SHW-1:0]   amt;
    logic             sign;
    logic [TAG_W-1:0] tag;
  } stage_t;

  stage_t         stage_q [SHW];
  logic [SHW-1:0] stage_valid;
  logic [SHW-1:0] stage_ready;
  logic           accept;

  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       mode,
    input logic             sign,
    input int               amt
  );
    logic [WIDTH-1:0] r;
    case (mode)
      MODE_SLL: r = d << amt;
      MODE_SRL: r = d >> amt;
      MODE_SRA: r = sign ? ((d >> amt) | ~({WIDTH{1'b1}} >> amt)) : (d >> amt);
      MODE_ROL: r = (d << amt) | (d >> (WIDTH - amt));
      MODE_ROR: r = (d >> amt) | (d << (WIDTH - amt));
      default:  r = '0;
    endcase
    return r;
  endfunction

  // A stage may load when it is empty or when something ahead of it will move,
  // which collapses the ready chain into a running OR from the output backwards.
  always_comb begin : ready_chain
    logic r;
    stage_ready = '0;
    r = bus.i_ready;
    for (int k = SHW - 1; k >= 0; k--) begin
      r = r | ~stage_valid[k];
      stage_ready[k] = r;
    end
  end

  assign bus.o_ready = stage_ready[0] & ~i_flush & ~i_rst;
  assign accept      = bus.i_valid & bus.o_ready;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int STEP = 1 << k;

    stage_t in_s;
    stage_t nxt_s;
    stage_t q_s;
    logic   in_v;
    logic   q_v;

    if (k == 0) begin : g_head
      assign in_v       = accept;
      assign in_s.data  = (bus.i_sel > 3'd4) ? '0 : bus.i_shifter_a;
      assign in_s.mode  = bus.i_sel;
      assign in_s.amt   = bus.i_shifter_b[SHW-1:0];
      assign in_s.sign  = bus.i_shifter_a[WIDTH-1];
      assign in_s.tag   = bus.i_tag;
    end else begin : g_body
      assign in_v = stage_valid[k-1];
      assign in_s = stage_q[k-1];
    end

    always_comb begin
      nxt_s      = in_s;
      nxt_s.data = in_s.amt[k] ? shift_step(in_s.data, in_s.mode, in_s.sign, STEP) : in_s.data;
    end

    // Flush only drops valids; payload is don't-care once its valid is gone.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        q_v <= 1'b0;
        q_s <= '0;
      end else if (i_flush) begin
        q_v <= 1'b0;
      end else if (stage_ready[k]) begin
        q_v <= in_v;
        if (in_v) begin
          q_s <= nxt_s;
        end
      end
    end

    assign stage_valid[k] = q_v;
    assign stage_q[k]     = q_s;
  end

  assign bus.o_valid = stage_valid[SHW-1];
  assign bus.o_data  = stage_q[SHW-1].data;
  assign bus.o_tag   = stage_q[SHW-1].tag;

  logic unused_bits;
  assign unused_bits = ^{bus.i_shifter_b[WIDTH-1:SHW], stage_q[SHW-1].mode,
                         stage_q[SHW-1].amt, stage_q[SHW-1].sign};

endmodule

// File: tb/tb_shifter_pipe.sv
// Scoreboard bench for shifter_pipe: accepted operations queue their expected
// result; a negedge monitor retires them against the DUT output in order.
module tb_shifter_pipe;
  localparam int WIDTH = 32;
  localparam int TAG_W = 4;
  localparam int SHW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  shifter_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  shifter_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_flush(flush),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cycle = 0;
  int          acc_count = 0;
  logic [31:0] exp_data = '0;
  bit          check_lat = 1'b0;
  bit          head_seen = 1'b0;

  logic [2:0]  v_sel [11] = '{3'd2, 3'd2, 3'd4, 3'd3, 3'd0, 3'd7, 3'd1, 3'd4, 3'd2, 3'd2, 3'd3};
  logic [31:0] v_a   [11] = '{32'h8000_0000, 32'h7000_0000, 32'h0000_00F1, 32'h8000_0001,
                              32'h0000_0001, 32'hDEAD_BEEF, 32'h8000_0000, 32'h1234_5678,
                              32'h7FFF_FFFF, 32'h8000_0000, 32'h1234_5678};
  logic [31:0] v_b   [11] = '{32'd4, 32'd4, 32'd4, 32'd1, 32'h21, 32'd3, 32'd31, 32'd0,
                              32'd31, 32'd31, 32'd16};
  logic [31:0] v_exp [11] = '{32'hF800_0000, 32'h0700_0000, 32'h1000_000F, 32'h0000_0003,
                              32'h0000_0002, 32'h0000_0000, 32'h0000_0001, 32'h1234_5678,
                              32'h0000_0000, 32'hFFFF_FFFF, 32'h5678_1234};

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor and acceptor share one negedge process so pops and pushes never race.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
      head_seen = 1'b0;
    end else begin
      if (bus.o_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got o_valid=1 data=0x%0h tag=%0d, expected no result",
                   bus.o_data, bus.o_tag);
        end else begin
          if (!head_seen && check_lat)
            check_output("latency", 32'(cycle - sb[0].cyc), 32'(SHW));
          head_seen = 1'b1;
          if (bus.i_ready) begin
            check_output("data", bus.o_data, sb[0].data);
            check_output("tag", 32'(bus.o_tag), 32'(sb[0].tag));
            void'(sb.pop_front());
            head_seen = 1'b0;
          end
        end
      end
      if (bus.i_valid && bus.o_ready) begin
        sb.push_back('{exp_data, bus.i_tag, cycle});
        acc_count++;
      end
    end
  end

  task automatic apply_stimulus(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] tag, input logic [31:0] exp);
    bit taken;
    taken           = 1'b0;
    bus.i_valid     = 1'b1;
    bus.i_sel       = sel;
    bus.i_shifter_a = a;
    bus.i_shifter_b = b;
    bus.i_tag       = tag;
    exp_data        = exp;
    for (int i = 0; i < 64 && !taken; i++) begin
      @(negedge clk);
      taken = bus.o_ready;
      @(posedge clk);
      #1;
    end
    if (!taken) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no accept for tag %0d, expected accept within 64 cycles", tag);
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0 && !bus.o_valid) break;
      @(posedge clk);
      #1;
    end
    check_output(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 100000 ns");
    $fatal(1);
  end

  initial begin
    bus.i_valid     = 1'b0;
    bus.i_sel       = 3'd0;
    bus.i_shifter_a = '0;
    bus.i_shifter_b = '0;
    bus.i_tag       = '0;
    bus.i_ready     = 1'b1;

    #2;
    check_output("rst_o_valid", 32'(bus.o_valid), 32'd0);
    check_output("rst_o_data", bus.o_data, 32'd0);
    check_output("rst_o_tag", 32'(bus.o_tag), 32'd0);
    check_output("rst_o_ready", 32'(bus.o_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_output("post_rst_o_ready", 32'(bus.o_ready), 32'd1);

    check_lat = 1'b1;
    for (int i = 0; i < 11; i++)
      apply_stimulus(v_sel[i], v_a[i], v_b[i], 4'(i + 1), v_exp[i]);
    wait_drain("directed_drain");

    for (int i = 0; i < 8; i++)
      apply_stimulus(3'd0, 32'd1, 32'(i), 4'(i), 32'd1 << i);
    wait_drain("stream_drain");

    check_lat   = 1'b0;
    acc_count   = 0;
    bus.i_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          apply_stimulus(3'd0, 32'd1, 32'(i), 4'(i), 32'd1 << i);
      end
      begin
        repeat (10) @(posedge clk);
        #2;
        check_output("bp_accepted", 32'(acc_count), 32'd5);
        check_output("bp_o_ready", 32'(bus.o_ready), 32'd0);
        check_output("bp_o_valid", 32'(bus.o_valid), 32'd1);
        check_output("bp_o_data", bus.o_data, 32'd1);
        check_output("bp_o_tag", 32'(bus.o_tag), 32'd0);
        repeat (3) begin
          @(posedge clk);
          #2;
          check_output("bp_hold_data", bus.o_data, 32'd1);
        end
        bus.i_ready = 1'b1;
      end
    join
    wait_drain("bp_drain");
    check_output("bp_total", 32'(acc_count), 32'd8);

    check_lat = 1'b1;
    for (int i = 0; i < 3; i++)
      apply_stimulus(3'd0, 32'd3, 32'(i), 4'(8 + i), 32'd3 << i);
    flush           = 1'b1;
    bus.i_valid     = 1'b1;
    bus.i_sel       = 3'd0;
    bus.i_shifter_a = 32'd5;
    bus.i_shifter_b = 32'd0;
    bus.i_tag       = 4'hF;
    exp_data        = 32'd5;
    #1;
    check_output("flush_o_ready", 32'(bus.o_ready), 32'd0);
    @(posedge clk);
    #1;
    flush       = 1'b0;
    bus.i_valid = 1'b0;
    check_output("flush_o_valid", 32'(bus.o_valid), 32'd0);
    repeat (6) begin
      @(posedge clk);
      #1;
      check_output("flush_empty", 32'(bus.o_valid), 32'd0);
    end
    apply_stimulus(3'd4, 32'd5, 32'd1, 4'hC, 32'h8000_0002);
    wait_drain("flush_drain");

    check_lat   = 1'b0;
    bus.i_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      apply_stimulus(3'd0, 32'h0000_00A5, 32'd1, 4'(i + 1), 32'h0000_014A);
    check_output("full_o_valid", 32'(bus.o_valid), 32'd1);
    check_output("full_o_data", bus.o_data, 32'h0000_014A);
    rst = 1'b1;
    #1;
    check_output("mid_rst_o_valid", 32'(bus.o_valid), 32'd0);
    check_output("mid_rst_o_data", bus.o_data, 32'd0);
    check_output("mid_rst_o_tag", 32'(bus.o_tag), 32'd0);
    check_output("mid_rst_o_ready", 32'(bus.o_ready), 32'd0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.i_ready = 1'b1;
    #1;
    check_output("mid_rst_release_ready", 32'(bus.o_ready), 32'd1);
    check_lat = 1'b1;
    apply_stimulus(3'd2, 32'h0000_00F0, 32'd4, 4'h3, 32'h0000_000F);
    wait_drain("rst_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shifter_pipe.md
# shifter_pipe

Parametrised, fully pipelined barrel shifter for the execute datapath. It supports five shift/rotate modes with a valid/ready handshake on both sides. The pipeline has one register stage per shift-amount bit, so it sustains one operation per cycle at any width. A tag travels alongside each operation, and a synchronous flush discards everything in flight. It is intended for the multi-cycle and pipelined CPU variants and for any wide-datapath unit that needs shifts with backpressure.

## Interface
Parameters:
- WIDTH, 32, data width; power of two, ≥ 8
- SHW, $clog2(WIDTH), derived; shift-amount width and pipeline depth
- TAG_W, 4, width of the sideband tag

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_flush  in  1  synchronous flush; clears all in-flight operations
- i_valid  in  1  input operation valid
- o_ready  out  1  block can accept an input this cycle
- i_sel  in  3  mode: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101–111 result zero
- i_shifter_a  in  WIDTH  operand to shift
- i_shifter_b  in  WIDTH  shift amount; only bits [SHW-1:0] are used
- i_tag  in  TAG_W  sideband, returned unchanged with the result
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts the result
- o_data  out  WIDTH  shifted result
- o_tag  out  TAG_W  tag of the result

## Operation
- An input is accepted when i_valid && o_ready at a rising edge.
- Pipeline structure:
  - There are SHW stage registers, 0 .. SHW-1.
  - Stage k applies a shift of 2^k when shift-amount bit k is 1, otherwise it passes the data through.
  - Each stage carries valid, data, mode, the remaining amount bits, the sign bit and the tag.
- Mode behaviour:
  - SLL fills with 0.
  - SRL fills with 0.
  - SRA fills with the original operand's bit WIDTH-1, which is captured at acceptance. Both positive and negative operands are handled correctly.
  - ROL and ROR rotate with no loss of bits.
  - Modes 101–111 produce all-zero data but still occupy a slot and still return the tag.
- A shift amount of 0 passes i_shifter_a through unchanged in modes 000–100.
- Backpressure:
  - ready_k = ~valid_k || ready_{k+1}, with ready_SHW = i_ready.
  - o_ready = ready_0 && ~i_flush && ~i_rst.
  - A stage that is not advancing holds its contents.
- Output handshake:
  - While o_valid && ~i_ready, o_data and o_tag hold stable.
  - o_valid never drops without a handshake, except on flush or reset.
- Ordering: results leave strictly in acceptance order.
- Flush:
  - i_flush clears every stage valid at the next edge.
  - An input presented in the same cycle is not accepted, because o_ready is 0.
  - The output handshake in that cycle is not counted as a transfer.
- Reset: i_rst asynchronously clears all valid, data and tag registers. This applies at any time, including mid-stream.

## Timing
- Reset values:
  - o_valid = 0, o_data = 0, o_tag = 0.
  - o_ready = 0 while i_rst is high, and 1 in the first cycle after release.
- Latency: an input accepted in cycle t is presented in cycle t+SHW with o_valid = 1. This is 5 cycles for WIDTH = 32.
- Throughput: 1 operation per cycle while i_ready = 1, with no bubbles.
- Full pipeline: with i_ready = 0, SHW operations can be accepted. o_ready then goes low combinationally in the cycle the pipeline is full.
- Release: o_ready rises in the same cycle that i_ready rises, so an accept and a retire can happen in the same cycle.
- o_ready depends combinationally on i_ready and i_flush. o_valid, o_data and o_tag are registered.

## Test plan
- Sign fill (WIDTH = 32), SRA by 4:
  - a = 0x8000_0000 -> 0xF800_0000.
  - a = 0x7000_0000 -> 0x0700_0000.
  - Each appears in cycle t+5.
- Rotates and logical shifts:
  - ROR 0x0000_00F1 by 4 -> 0x1000_000F.
  - ROL 0x8000_0001 by 1 -> 0x0000_0003.
  - SLL 0x1 with i_shifter_b = 0x21 -> 0x2 (upper amount bits ignored).
  - Mode 111 -> 0x0, with the tag returned.
- Streaming: 8 back-to-back SLL of 0x1 by amounts 0..7 with tags 0..7 and i_ready = 1.
  - Results are 0x1, 0x2, …, 0x80 in consecutive cycles 5..12, with tags 0..7.
- Backpressure: i_ready = 0 from the start, 8 inputs offered.
  - Exactly 5 are accepted and o_ready drops.
  - o_data holds 0x1, tag 0, while i_ready is low.
  - When i_ready is raised, all 8 results exit in order with no loss or duplication.
- Flush: assert i_flush for one cycle with 3 operations in flight while i_valid is high.
  - The next cycle has no o_valid for those 3 operations.
  - The input offered during the flush cycle is not accepted.
  - A new input issued afterwards returns after 5 cycles.
- Mid-stream reset: assert i_rst asynchronously with the pipeline full.
  - o_valid, o_data and o_tag go to 0 immediately.
  - After release, o_ready = 1 and the first result appears 5 cycles after the first accept.
